// File: rtl/demux_sequencer.sv
// Round-robin sequencer for a 1-to-8 demux: picks a requesting channel, presents it on a/b/c,
// then strobes e for HOLD_CYCLES with a guard cycle before and GAP_CYCLES after.
module demux_sequencer #(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       e,
   output logic       busy,
   output logic       done,
   output logic [2:0] done_ch
);

   localparam logic [7:0] HOLD_C = 8'(HOLD_CYCLES);
   localparam logic [7:0] GAP_C  = 8'(GAP_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRIVE = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] sel_q, sel_d;
   logic       e_q, e_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [2:0] done_ch_q, done_ch_d;

   logic       found_s;
   logic [2:0] grant_s;
   logic [2:0] idx_s;

   // Round-robin search: first requester strictly after the last grant, wrapping 7->0.
   always_comb begin
      found_s = 1'b0;
      grant_s = ptr_q;
      idx_s   = ptr_q;
      for (int i = 1; i <= 8; i++) begin
         idx_s = ptr_q + 3'(i);
         if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            grant_s = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      e_d       = 1'b0;
      done_d    = 1'b0;
      done_ch_d = done_ch_q;
      case (state_q)
         IDLE: begin
            if (en && found_s) begin
               sel_d   = grant_s;
               ptr_d   = grant_s;
               state_d = SETUP;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            e_d     = 1'b1;
            cnt_d   = 8'd1;
            state_d = DRIVE;
         end
         DRIVE: begin
            if (cnt_q == HOLD_C) begin
               done_d    = 1'b1;
               done_ch_d = sel_q;
               cnt_d     = 8'd1;
               state_d   = GAP;
            end else begin
               e_d   = 1'b1;
               cnt_d = cnt_q + 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_C) begin
               cnt_d   = 8'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            cnt_d   = 8'd0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; pointer resets to 7 so the first search begins at channel 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         ptr_q     <= 3'd7;
         sel_q     <= 3'd0;
         e_q       <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_ch_q <= 3'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         sel_q     <= sel_d;
         e_q       <= e_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         done_ch_q <= done_ch_d;
      end
   end

   assign a       = sel_q[2];
   assign b       = sel_q[1];
   assign c       = sel_q[0];
   assign e       = e_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign done_ch = done_ch_q;

endmodule

// File: tb/tb_demux_sequencer.sv
// Bench for demux_sequencer: directed scenarios plus random traffic, checked every cycle against
// a timeline model (cycles since grant) and against fixed expected grant orders.
module tb_demux_sequencer;

   localparam int HOLD = 4;
   localparam int GAP  = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] req = 8'h00;
   logic       a, b, c, e, busy, done;
   logic [2:0] done_ch;

   int total = 0;
   int bad = 0;

   // timeline model state
   bit         m_act;
   int         m_t;
   int         m_ptr;
   logic [2:0] m_sel;
   logic [2:0] m_done_ch;

   logic       prev_e;
   int         grants[$];

   demux_sequencer #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req),
      .a(a), .b(b), .c(c), .e(e), .busy(busy), .done(done), .done_ch(done_ch)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_act = 1'b0; m_t = 0; m_ptr = 7; m_sel = 3'd0; m_done_ch = 3'd0;
   endfunction

   function automatic void model_edge(input logic rst_v, input logic en_v, input logic [7:0] req_v);
      if (!rst_v) begin
         model_reset();
      end else if (m_act) begin
         if (m_t == HOLD + GAP) m_act = 1'b0;
         else begin
            m_t++;
            if (m_t == HOLD + 1) m_done_ch = m_sel;
         end
      end else if (en_v && req_v != 8'h00) begin
         for (int k = 1; k <= 8; k++) begin
            int ch;
            ch = (m_ptr + k) % 8;
            if (req_v[ch]) begin
               m_ptr = ch;
               m_sel = 3'(ch);
               m_act = 1'b1;
               m_t = 0;
               break;
            end
         end
      end
   endfunction

   task automatic compare_outputs();
      check_val("sel",  {29'd0, a, b, c}, {29'd0, m_sel});
      check_val("e",    {31'd0, e},    {31'd0, (m_act && m_t >= 1 && m_t <= HOLD)});
      check_val("busy", {31'd0, busy}, {31'd0, m_act});
      check_val("done", {31'd0, done}, {31'd0, (m_act && m_t == HOLD + 1)});
      if (done) check_val("done_ch", {29'd0, done_ch}, {29'd0, m_done_ch});
      if (e && !prev_e) grants.push_back(int'({a, b, c}));
      prev_e = e;
   endtask

   // One clock: check at the falling edge, drive new inputs, then advance the model at the rising edge.
   task automatic cyc(input logic rst_v, input logic en_v, input logic [7:0] req_v);
      @(negedge clk);
      compare_outputs();
      rst_n = rst_v; en = en_v; req = req_v;
      @(posedge clk);
      model_edge(rst_v, en_v, req_v);
   endtask

   task automatic wait_e(input string tag, input logic en_v, input logic [7:0] req_v);
      int n;
      n = 0;
      while (!e && n < 20) begin
         cyc(1'b1, en_v, req_v);
         n++;
      end
      check_val({tag, "_e_timeout"}, {31'd0, e}, 32'd1);
   endtask

   task automatic hard_reset();
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b1, 1'b0, 8'h00);
      grants.delete();
   endtask

   initial begin
      model_reset();
      prev_e = 1'b0;

      // reset held with requests pending
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'hFF);
      check_val("rst_done_ch", {29'd0, done_ch}, 32'd0);
      cyc(1'b1, 1'b1, 8'hFF);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h00);
      check_val("first_grant", grants.size() > 0 ? grants[0] : -1, 32'd0);

      // single request on channel 5
      hard_reset();
      cyc(1'b1, 1'b1, 8'h20);
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 8'h00);
      check_val("single_cnt", grants.size(), 32'd1);
      check_val("single_ch", grants.size() > 0 ? grants[0] : -1, 32'd5);

      // round robin between 0 and 7
      hard_reset();
      for (int i = 0; i < 29; i++) cyc(1'b1, 1'b1, 8'h81);
      check_val("rr_cnt", grants.size(), 32'd4);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check_val("rr_ch", grants[i], (i % 2 == 0) ? 32'd0 : 32'd7);

      // request switches mid-grant
      hard_reset();
      cyc(1'b1, 1'b1, 8'h08);
      wait_e("chg", 1'b1, 8'h00);
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 8'h40);
      cyc(1'b1, 1'b1, 8'h00);
      check_val("chg_cnt", grants.size() >= 2, 32'd1);
      if (grants.size() >= 2) begin
         check_val("chg_first", grants[0], 32'd3);
         check_val("chg_next", grants[1], 32'd6);
      end

      // en dropped during DRIVE: grant finishes, then no new grant until en returns
      hard_reset();
      cyc(1'b1, 1'b1, 8'hFF);
      wait_e("en", 1'b1, 8'hFF);
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 8'hFF);
      check_val("en_hold_cnt", grants.size(), 32'd1);
      check_val("en_hold_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'hFF);
      check_val("en_resume_cnt", grants.size(), 32'd2);
      if (grants.size() >= 2) check_val("en_resume_ch", grants[1], 32'd1);

      // asynchronous reset between edges while e is high
      hard_reset();
      cyc(1'b1, 1'b1, 8'h04);
      wait_e("arst", 1'b1, 8'h00);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_e", {31'd0, e}, 32'd0);
      check_val("arst_busy", {31'd0, busy}, 32'd0);
      check_val("arst_sel", {29'd0, a, b, c}, 32'd0);
      model_reset();
      prev_e = 1'b0;
      grants.delete();
      cyc(1'b0, 1'b1, 8'h10);
      cyc(1'b1, 1'b1, 8'h10);
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 8'h00);
      check_val("arst_grant", grants.size() > 0 ? grants[0] : -1, 32'd4);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [7:0] r;
         r = 8'($urandom) & 8'($urandom);
         cyc(($urandom % 200) != 0, ($urandom % 4) != 0, r);
      end
      cyc(1'b1, 1'b0, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
